// File: rtl/seg7_decimal_display_if.sv
// CPU-to-display bundle: data/signedness from the CPU, four digit drives and busy back.
interface seg7_decimal_display_if;
  logic [7:0] value;
  logic       non_signed;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;
  logic       busy;

  modport master (
    output value,
    output non_signed,
    input  hex0,
    input  hex1,
    input  hex2,
    input  hex3,
    input  busy
  );

  modport slave (
    input  value,
    input  non_signed,
    output hex0,
    output hex1,
    output hex2,
    output hex3,
    output busy
  );
endinterface

// File: rtl/seg7_decimal_display.sv
// Converts the CPU data byte to sign/hundreds/tens/units on four seven-segment digits
// via an 8-step double-dabble; the display refreshes 9 edges after each input capture.
module seg7_decimal_display #(
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  seg7_decimal_display_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_snap_value;
  logic        r_snap_ns;
  logic        r_force;
  logic        r_neg;
  logic [7:0]  r_mag;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic [6:0]  r_hex0;
  logic [6:0]  r_hex1;
  logic [6:0]  r_hex2;
  logic [6:0]  r_hex3;

  logic        w_capture;
  logic        w_busy;
  logic        w_neg_in;
  logic [7:0]  w_mag_in;
  logic [11:0] w_bcd_adj;
  logic [3:0]  w_hund;
  logic [3:0]  w_tens;
  logic [3:0]  w_units;
  logic [6:0]  w_hex0_nxt;
  logic [6:0]  w_hex1_nxt;
  logic [6:0]  w_hex2_nxt;
  logic [6:0]  w_hex3_nxt;

  function automatic logic [6:0] f_digit(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

  function automatic logic [6:0] f_pol(input logic [6:0] c);
    return SEG_ACTIVE_LOW ? c : ~c;
  endfunction

  function automatic logic [3:0] f_add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_capture) w_state_nxt = CONV;
      CONV:    if (r_cnt == 3'd7) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != IDLE);
    w_capture = (r_state == IDLE) &&
                (r_force || (bus.value != r_snap_value) || (bus.non_signed != r_snap_ns));
    w_neg_in  = !bus.non_signed && bus.value[7];
    // 0x80 negates to itself, which read as unsigned is the wanted 128
    w_mag_in  = w_neg_in ? (~bus.value + 8'd1) : bus.value;
    w_bcd_adj = {f_add3(r_bcd[11:8]), f_add3(r_bcd[7:4]), f_add3(r_bcd[3:0])};
    w_hund    = r_bcd[11:8];
    w_tens    = r_bcd[7:4];
    w_units   = r_bcd[3:0];
    w_hex3_nxt = f_pol(r_neg ? SEG_MINUS : SEG_BLANK);
    w_hex2_nxt = f_pol((BLANK_LEADING && (w_hund == 4'd0)) ? SEG_BLANK : f_digit(w_hund));
    w_hex1_nxt = f_pol((BLANK_LEADING && (w_hund == 4'd0) && (w_tens == 4'd0))
                       ? SEG_BLANK : f_digit(w_tens));
    w_hex0_nxt = f_pol(f_digit(w_units));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_snap_value <= 8'd0;
      r_snap_ns    <= 1'b0;
      r_force      <= 1'b1;
      r_neg        <= 1'b0;
      r_mag        <= 8'd0;
      r_bcd        <= 12'd0;
      r_cnt        <= 3'd0;
      r_hex0       <= f_pol(SEG_BLANK);
      r_hex1       <= f_pol(SEG_BLANK);
      r_hex2       <= f_pol(SEG_BLANK);
      r_hex3       <= f_pol(SEG_BLANK);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_capture) begin
            r_snap_value <= bus.value;
            r_snap_ns    <= bus.non_signed;
            r_force      <= 1'b0;
            r_neg        <= w_neg_in;
            r_mag        <= w_mag_in;
            r_bcd        <= 12'd0;
            r_cnt        <= 3'd0;
          end
        end
        CONV: begin
          {r_bcd, r_mag} <= {w_bcd_adj[10:0], r_mag, 1'b0};
          r_cnt          <= r_cnt + 3'd1;
        end
        DONE: begin
          r_hex0 <= w_hex0_nxt;
          r_hex1 <= w_hex1_nxt;
          r_hex2 <= w_hex2_nxt;
          r_hex3 <= w_hex3_nxt;
        end
        default: ;
      endcase
    end
  end

  assign bus.hex0 = r_hex0;
  assign bus.hex1 = r_hex1;
  assign bus.hex2 = r_hex2;
  assign bus.hex3 = r_hex3;
  assign bus.busy = w_busy;

endmodule

// File: tb/tb_seg7_decimal_display.sv
// Bench for seg7_decimal_display: three instances (default, no blanking, active-high
// segments) share one stimulus stream and are checked against an arithmetic reference.
module tb_seg7_decimal_display;
  logic       clk;
  logic       resetn;
  logic [7:0] tb_value;
  logic       tb_ns;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [27:0] exp_a, exp_b, exp_c;
  logic [27:0] disp_a, disp_b, disp_c;

  seg7_decimal_display_if u_if_a ();
  seg7_decimal_display_if u_if_b ();
  seg7_decimal_display_if u_if_c ();

  assign u_if_a.value = tb_value;
  assign u_if_b.value = tb_value;
  assign u_if_c.value = tb_value;
  assign u_if_a.non_signed = tb_ns;
  assign u_if_b.non_signed = tb_ns;
  assign u_if_c.non_signed = tb_ns;
  assign disp_a = {u_if_a.hex3, u_if_a.hex2, u_if_a.hex1, u_if_a.hex0};
  assign disp_b = {u_if_b.hex3, u_if_b.hex2, u_if_b.hex1, u_if_b.hex0};
  assign disp_c = {u_if_c.hex3, u_if_c.hex2, u_if_c.hex1, u_if_c.hex0};

  seg7_decimal_display #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) u_dut_a (
    .clk(clk), .resetn(resetn), .bus(u_if_a));
  seg7_decimal_display #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) u_dut_b (
    .clk(clk), .resetn(resetn), .bus(u_if_b));
  seg7_decimal_display #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b1)) u_dut_c (
    .clk(clk), .resetn(resetn), .bus(u_if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Decimal reference: interpret, take magnitude, split into digits arithmetically.
  function automatic logic [27:0] model(input logic [7:0] v, input logic ns,
                                        input bit bl, input bit al);
    int n, m, hu, te, un;
    logic [6:0] h3, h2, h1, h0;
    n = int'(v);
    if (!ns && n >= 128) n = n - 256;
    m  = (n < 0) ? -n : n;
    hu = m / 100;
    te = (m / 10) % 10;
    un = m % 10;
    h3 = (n < 0) ? 7'h3F : 7'h7F;
    h2 = (bl && hu == 0) ? 7'h7F : seg_tab[hu];
    h1 = (bl && hu == 0 && te == 0) ? 7'h7F : seg_tab[te];
    h0 = seg_tab[un];
    return al ? {h3, h2, h1, h0} : ~{h3, h2, h1, h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_expect(input logic [7:0] v, input logic ns);
    exp_a = model(v, ns, 1'b1, 1'b1);
    exp_b = model(v, ns, 1'b0, 1'b1);
    exp_c = model(v, ns, 1'b1, 1'b0);
  endtask

  task automatic set_blank();
    exp_a = {4{7'h7F}};
    exp_b = {4{7'h7F}};
    exp_c = '0;
  endtask

  task automatic check_disp(input string tag);
    chk({tag, ".a.hex0"}, disp_a[6:0],   exp_a[6:0]);
    chk({tag, ".a.hex1"}, disp_a[13:7],  exp_a[13:7]);
    chk({tag, ".a.hex2"}, disp_a[20:14], exp_a[20:14]);
    chk({tag, ".a.hex3"}, disp_a[27:21], exp_a[27:21]);
    chk({tag, ".b.hex0"}, disp_b[6:0],   exp_b[6:0]);
    chk({tag, ".b.hex1"}, disp_b[13:7],  exp_b[13:7]);
    chk({tag, ".b.hex2"}, disp_b[20:14], exp_b[20:14]);
    chk({tag, ".b.hex3"}, disp_b[27:21], exp_b[27:21]);
    chk({tag, ".c.hex0"}, disp_c[6:0],   exp_c[6:0]);
    chk({tag, ".c.hex1"}, disp_c[13:7],  exp_c[13:7]);
    chk({tag, ".c.hex2"}, disp_c[20:14], exp_c[20:14]);
    chk({tag, ".c.hex3"}, disp_c[27:21], exp_c[27:21]);
  endtask

  // Drive a new input; the next edge captures it. Counts busy cycles and verifies
  // the previous display is held until the conversion finishes.
  task automatic run_conv(input string tag, input logic [7:0] v, input logic ns);
    int n;
    bit held;
    tb_value = v;
    tb_ns    = ns;
    n    = 0;
    held = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (!u_if_a.busy) break;
      n++;
      if (disp_a !== exp_a || disp_b !== exp_b || disp_c !== exp_c) held = 1'b0;
    end
    chk({tag, ".busy_cycles"}, n, 9);
    chk({tag, ".held"}, {31'd0, held}, 1);
    set_expect(v, ns);
    check_disp(tag);
  endtask

  initial begin
    int n;
    logic [7:0] rv;
    logic       rns;

    resetn   = 1'b0;
    tb_value = 8'h00;
    tb_ns    = 1'b1;
    repeat (3) tick();
    set_blank();
    check_disp("reset");
    chk("reset.busy", {31'd0, u_if_a.busy}, 0);

    resetn = 1'b1;
    run_conv("zero", 8'h00, 1'b1);
    run_conv("u255", 8'hFF, 1'b1);
    run_conv("s_m1", 8'hFF, 1'b0);
    run_conv("s_m128", 8'h80, 1'b0);
    run_conv("s_127", 8'h7F, 1'b0);

    // 5 captured at E, 7 arrives after E+3 and is captured at E+10
    tb_value = 8'd5;
    tb_ns    = 1'b1;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (u_if_a.busy) n++;
    end
    tb_value = 8'd7;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (!u_if_a.busy) break;
      n++;
    end
    chk("five.busy_cycles", n, 9);
    set_expect(8'd5, 1'b1);
    check_disp("five");
    tick();
    chk("seven.recapture_busy", {31'd0, u_if_a.busy}, 1);
    n = 1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (!u_if_a.busy) break;
      n++;
    end
    chk("seven.busy_cycles", n, 9);
    set_expect(8'd7, 1'b1);
    check_disp("seven");

    // reset one edge while the conversion is at cnt==4
    tb_value = 8'hC8;
    tb_ns    = 1'b1;
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    set_blank();
    check_disp("rst_mid");
    chk("rst_mid.busy", {31'd0, u_if_a.busy}, 0);
    resetn = 1'b1;
    n = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (u_if_a.busy) n++;
    end
    chk("rst_mid.busy_cycles", n, 9);
    check_disp("rst_hold");
    tick();
    chk("rst_done.busy", {31'd0, u_if_a.busy}, 0);
    set_expect(8'hC8, 1'b1);
    check_disp("rst_done");

    run_conv("seven_b", 8'd7, 1'b1);

    for (int i = 0; i < 25; i++) begin
      rv  = 8'($urandom_range(0, 255));
      rns = 1'($urandom_range(0, 1));
      if (rv == tb_value && rns == tb_ns) rns = ~rns;
      run_conv($sformatf("rand%0d", i), rv, rns);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
